// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Arbitrates a fetch port and a data port onto one unified memory.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int D_STREAK_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              stall_f,
  output logic              stall_m,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              err
);

  localparam int SW = (D_STREAK_MAX < 1) ? 1 : $clog2(D_STREAK_MAX + 1);
  localparam logic [SW-1:0] c_streak_max = SW'(D_STREAK_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2
  } state_t;

  state_t        r_state;
  logic [SW-1:0] r_streak;
  logic          w_pulse;
  logic          w_grant_d;

  // Requesters still hold req during their valid pulse, so no grant that cycle.
  assign w_pulse   = i_valid | d_valid;
  assign w_grant_d = d_req & (~i_req | (r_streak < c_streak_max));

  assign stall_f = i_req & ~i_valid;
  assign stall_m = d_req & ~d_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_streak  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_valid   <= 1'b0;
      d_valid   <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      err       <= 1'b0;
    end else begin
      i_valid <= 1'b0;
      d_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (mem_ready) begin
            err <= 1'b1;
          end
          if (!w_pulse) begin
            if (w_grant_d) begin
              r_state   <= DACC;
              mem_req   <= 1'b1;
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              if (!i_req) begin
                r_streak <= '0;
              end else if (r_streak < c_streak_max) begin
                r_streak <= r_streak + SW'(1);
              end
            end else if (i_req) begin
              r_state   <= IACC;
              mem_req   <= 1'b1;
              mem_we    <= 1'b0;
              mem_addr  <= i_addr;
              mem_wdata <= '0;
              r_streak  <= '0;
            end
          end
        end
        IACC: begin
          if (mem_ready) begin
            i_rdata <= mem_rdata;
            i_valid <= 1'b1;
            mem_req <= 1'b0;
            r_state <= IDLE;
          end
        end
        DACC: begin
          if (mem_ready) begin
            // Stores complete without disturbing the last load result.
            if (!mem_we) begin
              d_rdata <= mem_rdata;
            end
            d_valid <= 1'b1;
            mem_req <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: address width of all ports.
REQ-002 SHALL have parameter DATA_W, default 32: data width of all ports.
REQ-003 SHALL have parameter D_STREAK_MAX, default 4: consecutive data grants allowed while fetch waits.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port i_req  input  1  fetch-stage read request; held high until i_valid.
REQ-007 SHALL have port i_addr  input  ADDR_W  fetch address; stable while i_req high.
REQ-008 SHALL have port i_rdata  output  DATA_W  fetched instruction.
REQ-009 SHALL have port i_valid  output  1  one-cycle pulse; i_rdata valid.
REQ-010 SHALL have port d_req  input  1  memory-stage request; held high until d_valid.
REQ-011 SHALL have port d_we  input  1  1 = write, 0 = read.
REQ-012 SHALL have port d_addr  input  ADDR_W  data address.
REQ-013 SHALL have port d_wdata  input  DATA_W  store data.
REQ-014 SHALL have port d_rdata  output  DATA_W  load data.
REQ-015 SHALL have port d_valid  output  1  one-cycle pulse; data access complete.
REQ-016 SHALL have port stall_f  output  1  fetch stall to hazard logic.
REQ-017 SHALL have port stall_m  output  1  memory-stage stall to hazard logic.
REQ-018 SHALL have port mem_req  output  1  unified-memory request, held until mem_ready.
REQ-019 SHALL have ports mem_we (output 1), mem_addr (output ADDR_W), mem_wdata (output DATA_W): registered access attributes.
REQ-020 SHALL have ports mem_rdata (input DATA_W) and mem_ready (input 1): one-cycle completion pulse, any latency >= 1 cycle.
REQ-021 SHALL have port err  output  1  sticky protocol-error flag.

Function
REQ-022 SHALL implement FSM states IDLE, IACC, DACC.
REQ-023 In IDLE, SHALL grant data (go DACC) if d_req and (!i_req or streak < D_STREAK_MAX); else grant fetch (go IACC) if i_req; else stay IDLE.
REQ-024 On grant, SHALL register the granted port's address/we/wdata into mem_addr/mem_we/mem_wdata and assert mem_req from the next cycle; fetch grants SHALL drive mem_we = 0.
REQ-025 mem_req SHALL be 1 exactly in IACC/DACC; mem_addr/mem_we/mem_wdata SHALL stay constant throughout.
REQ-026 On mem_ready in IACC/DACC: latch mem_rdata into i_rdata/d_rdata, pulse i_valid/d_valid next cycle, return to IDLE; minimum access = grant cycle + 1 memory cycle; next grant earliest the cycle after the valid pulse.
REQ-027 For data writes, d_valid SHALL pulse and d_rdata SHALL retain its previous value.
REQ-028 streak counter (width ceil(log2(D_STREAK_MAX+1))): data grant with i_req high -> increment, saturating at D_STREAK_MAX; fetch grant or data grant with i_req low -> 0.
REQ-029 stall_f SHALL equal i_req & !i_valid; stall_m SHALL equal d_req & !d_valid (combinational).
REQ-030 i_rdata/d_rdata SHALL hold their last value until the next completion on that port.
REQ-031 mem_ready while IDLE SHALL be ignored for data and SHALL set err; err cleared only by reset.
REQ-032 Requests dropped mid-access (protocol violation) SHALL NOT abort the memory access; completion still pulses valid.

Reset
REQ-033 While reset is high at a clock edge: state = IDLE, streak = 0, mem_req/mem_we = 0, mem_addr/mem_wdata = 0, i_valid/d_valid = 0, i_rdata/d_rdata = 0, err = 0.
REQ-034 Reset asserted mid-access SHALL abandon the access without a valid pulse; memory shares the same reset.

Verification
REQ-035 Fetch only: i_req=1, i_addr=0x00000010, memory latency 2, mem_rdata=0x00500093 -> mem_req rises the cycle after request, i_valid one cycle with i_rdata=0x00500093, stall_f high until then.
REQ-036 Simultaneous i_req/d_req (d_we=0, d_addr=0x100, data 0xDEADBEEF) -> data granted first, d_rdata=0xDEADBEEF, then fetch granted; stall_f high across both.
REQ-037 Starvation: d_req held continuously, i_req high, D_STREAK_MAX=4 -> exactly 4 data accesses, then one fetch, then streak restarts.
REQ-038 Store: d_we=1, d_addr=0x200, d_wdata=0x12345678 -> mem_we=1, mem_wdata=0x12345678 held until mem_ready; d_valid pulses; d_rdata unchanged.
REQ-039 Reset during DACC with memory latency 5 -> next cycle mem_req=0, state IDLE, no d_valid; stray mem_ready in IDLE -> err=1 and stays 1 until reset.
